// File: rtl/avalon_timer_pkg.sv
// avalon_timer_pkg
//   Shared definitions for the avalon_multi_timer slice: per-channel register
//   offsets, CONTROL/STATUS bit positions and the address-width helper.
//   Build option: AVALON_TIMER_CAPTURE_EN (see avalon_multi_timer.sv).
package avalon_timer_pkg;

  // Register offsets inside one channel's 4-word window.
  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_offset_e;

  // STATUS bit positions.
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;
  localparam int ST_CAP = 2;

  // CONTROL bit positions (START/STOP are write-only strobes).
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;
  localparam int CTL_CAPIE = 4;

  // Word-address width: two register-select bits plus the channel field.
  function automatic int addr_width(input int num_ch);
    int w;
    if (num_ch <= 1) begin
      w = 2;
    end else begin
      w = $clog2(num_ch) + 2;
    end
    return w;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel
//   One interval-timer channel: down-counter, PERIOD, CONTROL, sticky
//   STATUS flags, snapshot register and (optionally) a synchronised
//   external capture input.
//   Ports:
//     clk, reset_n        clock, async active-low reset
//     wr_en               bus write addressed to this channel
//     reg_sel[1:0]        register offset inside the channel
//     writedata[31:0]     bus write data
//     capture_in          async capture trigger (AVALON_TIMER_CAPTURE_EN only)
//     rd_data[31:0]       combinational read value for reg_sel
//     irq                 (TO & ITO) | (CAP & CAPIE)
//   Build option: AVALON_TIMER_CAPTURE_EN adds the capture path, CAP and CAPIE.
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int          COUNT_W      = 32,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] writedata,
`ifdef AVALON_TIMER_CAPTURE_EN
  input  logic        capture_in,
`endif
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam logic [COUNT_W-1:0] RST_COUNT = COUNT_W'(RESET_PERIOD);
  localparam logic [COUNT_W-1:0] ZERO      = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] ONE       = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] period_r;
  logic [COUNT_W-1:0] snap_r;
  logic               run_r;
  logic               to_r;
  logic               ito_r;
  logic               cont_r;

  logic [COUNT_W-1:0] wdata_s;
  logic               wr_status_s;
  logic               wr_control_s;
  logic               wr_period_s;
  logic               wr_snap_s;
  logic               start_s;
  logic               stop_s;
  logic               timeout_s;
  logic               cap_rise_s;
  logic               cap_flag_s;
  logic               capie_s;
  logic               unused_wdata_s;

  assign wdata_s      = writedata[COUNT_W-1:0];
  assign wr_status_s  = wr_en && (reg_sel == REG_STATUS);
  assign wr_control_s = wr_en && (reg_sel == REG_CONTROL);
  assign wr_period_s  = wr_en && (reg_sel == REG_PERIOD);
  assign wr_snap_s    = wr_en && (reg_sel == REG_SNAP);
  assign start_s      = wr_control_s && writedata[CTL_START];
  assign stop_s       = wr_control_s && writedata[CTL_STOP];
  assign timeout_s    = run_r && (count_r == ZERO);
  // Bits above COUNT_W and undefined CONTROL bits are deliberately ignored.
  assign unused_wdata_s = ^writedata;

`ifdef AVALON_TIMER_CAPTURE_EN
  // [0],[1] synchroniser stages, [2] previous synchronised level for edge detect.
  logic [2:0] cap_sync_r;
  logic       cap_r;
  logic       capie_r;

  // Capture input synchroniser and edge-detect history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_sync_r <= 3'b000;
    end else begin
      cap_sync_r <= {cap_sync_r[1:0], capture_in};
    end
  end

  assign cap_rise_s = cap_sync_r[1] & ~cap_sync_r[2];

  // Sticky CAP flag; a STATUS write beats a coincident capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_r <= 1'b0;
    end else if (wr_status_s) begin
      cap_r <= 1'b0;
    end else if (cap_rise_s) begin
      cap_r <= 1'b1;
    end else begin
      cap_r <= cap_r;
    end
  end

  // Capture interrupt enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capie_r <= 1'b0;
    end else if (wr_control_s) begin
      capie_r <= writedata[CTL_CAPIE];
    end else begin
      capie_r <= capie_r;
    end
  end

  assign cap_flag_s = cap_r;
  assign capie_s    = capie_r;
`else
  assign cap_rise_s = 1'b0;
  assign cap_flag_s = 1'b0;
  assign capie_s    = 1'b0;
`endif

  // Down-counter: a PERIOD write reloads immediately and overrides a timeout reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= RST_COUNT;
    end else if (wr_period_s) begin
      count_r <= wdata_s;
    end else if (timeout_s) begin
      count_r <= period_r;
    end else if (run_r) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // RUN: PERIOD write > START > STOP > one-shot timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_r <= 1'b0;
    end else if (wr_period_s) begin
      run_r <= 1'b0;
    end else if (start_s) begin
      run_r <= 1'b1;
    end else if (stop_s) begin
      run_r <= 1'b0;
    end else if (timeout_s && !cont_r) begin
      run_r <= 1'b0;
    end else begin
      run_r <= run_r;
    end
  end

  // PERIOD register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_r <= RST_COUNT;
    end else if (wr_period_s) begin
      period_r <= wdata_s;
    end else begin
      period_r <= period_r;
    end
  end

  // Sticky TO flag; a STATUS write beats a coincident timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_r <= 1'b0;
    end else if (wr_status_s) begin
      to_r <= 1'b0;
    end else if (timeout_s) begin
      to_r <= 1'b1;
    end else begin
      to_r <= to_r;
    end
  end

  // Stored CONTROL bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ito_r  <= 1'b0;
      cont_r <= 1'b0;
    end else if (wr_control_s) begin
      ito_r  <= writedata[CTL_ITO];
      cont_r <= writedata[CTL_CONT];
    end else begin
      ito_r  <= ito_r;
      cont_r <= cont_r;
    end
  end

  // Snapshot: software SNAP write and capture both sample the pre-edge count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_r <= ZERO;
    end else if (wr_snap_s || cap_rise_s) begin
      snap_r <= count_r;
    end else begin
      snap_r <= snap_r;
    end
  end

  // Register read view for the selected offset, zero-extended.
  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      REG_STATUS: begin
        rd_data[ST_TO]  = to_r;
        rd_data[ST_RUN] = run_r;
        rd_data[ST_CAP] = cap_flag_s;
      end
      REG_CONTROL: begin
        rd_data[CTL_ITO]   = ito_r;
        rd_data[CTL_CONT]  = cont_r;
        rd_data[CTL_CAPIE] = capie_s;
      end
      REG_PERIOD: rd_data[COUNT_W-1:0] = period_r;
      REG_SNAP:   rd_data[COUNT_W-1:0] = snap_r;
      default:    rd_data = 32'd0;
    endcase
  end

  assign irq = (to_r & ito_r) | (cap_flag_s & capie_s);

endmodule

// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer
//   NUM_CH independent COUNT_W-bit interval timers behind one Avalon-MM slave.
//   Word address [1:0] selects STATUS/CONTROL/PERIOD/SNAP, upper bits the
//   channel. Channels >= NUM_CH read 0 and ignore writes.
//   Ports:
//     clk, reset_n          clock, async active-low reset
//     address               word address, clog2(NUM_CH)+2 bits
//     chipselect, write_n   slave select, active-low write strobe
//     writedata[31:0]       write data
//     readdata[31:0]        registered read data (1-cycle latency, always updated)
//     irq                   OR of irq_vec
//     irq_vec[NUM_CH-1:0]   per-channel interrupt
//     capture_in[NUM_CH-1:0] async capture triggers (AVALON_TIMER_CAPTURE_EN only)
//   Build option: define AVALON_TIMER_CAPTURE_EN for external capture support.
module avalon_multi_timer
  import avalon_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          COUNT_W      = 32,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [addr_width(NUM_CH)-1:0]   address,
  input  logic                            chipselect,
  input  logic                            write_n,
  input  logic [31:0]                     writedata,
  output logic [31:0]                     readdata,
  output logic                            irq,
  output logic [NUM_CH-1:0]               irq_vec
`ifdef AVALON_TIMER_CAPTURE_EN
  ,
  input  logic [NUM_CH-1:0]               capture_in
`endif
);

  localparam int AW  = addr_width(NUM_CH);
  // Channel field with one spare bit so a single-channel build still has one.
  localparam int CHW = AW - 1;

  logic [CHW-1:0] ch_sel_s;
  logic [1:0]     reg_sel_s;
  logic           bus_wr_s;
  logic [31:0]    rd_mux_s;
  logic [31:0]    rd_data_s [NUM_CH];

  assign ch_sel_s  = CHW'({1'b0, address} >> 2);
  assign reg_sel_s = address[1:0];
  assign bus_wr_s  = chipselect && !write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .COUNT_W      (COUNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_channel (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (bus_wr_s && (ch_sel_s == CHW'(i))),
      .reg_sel    (reg_sel_s),
      .writedata  (writedata),
`ifdef AVALON_TIMER_CAPTURE_EN
      .capture_in (capture_in[i]),
`endif
      .rd_data    (rd_data_s[i]),
      .irq        (irq_vec[i])
    );
  end

  // Read mux; unmatched (out-of-range) channels leave the result at zero.
  always_comb begin
    rd_mux_s = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_mux_s = rd_mux_s | (rd_data_s[i] & {32{ch_sel_s == CHW'(i)}});
    end
  end

  // Read data register, refreshed every cycle from the current address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      readdata <= rd_mux_s;
    end
  end

  assign irq = |irq_vec;

endmodule
